// File: rtl/if_inst_queue_pkg.sv
// Shared types and defaults for the fetch-to-dispatch instruction queue.
package if_inst_queue_pkg;

   localparam int XLEN             = 32;
   localparam int INST_QUEUE_DEPTH = 8;
   localparam int INST_QUEUE_SKID  = 1;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] NPC;
      logic [31:0]     inst;
   } IF_ID_PACKET;

endpackage

// File: rtl/if_inst_queue_fifo_ctrl.sv
// Pointer, occupancy and handshake control for the instruction queue.
module if_inst_queue_fifo_ctrl #(
   parameter int DEPTH = 8,
   parameter int PW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          flush,
   input  logic          enq_valid,
   input  logic          deq_ready,
   output logic          do_push,
   output logic          do_pop,
   output logic          full,
   output logic          empty,
   output logic [PW-1:0] head,
   output logic [PW-1:0] tail,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next
);

   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

   logic [PW-1:0] head_reg, head_next;
   logic [PW-1:0] tail_reg, tail_next;
   logic [CW-1:0] count_reg;

   assign full  = (count_reg == FULL_LEVEL);
   assign empty = (count_reg == '0);

   // A pop on the same edge frees the slot, so a full queue may still accept.
   assign do_pop  = !empty && deq_ready && !flush;
   assign do_push = enq_valid && !flush && (!full || do_pop);

   always_comb begin
      head_next  = head_reg;
      tail_next  = tail_reg;
      count_next = count_reg;
      if (flush) begin
         head_next  = '0;
         tail_next  = '0;
         count_next = '0;
      end else begin
         if (do_pop)
            head_next = head_reg + PW'(1);
         if (do_push)
            tail_next = tail_reg + PW'(1);
         count_next = count_reg + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
      end else begin
         head_reg  <= head_next;
         tail_reg  <= tail_next;
         count_reg <= count_next;
      end
   end

   assign head  = head_reg;
   assign tail  = tail_reg;
   assign count = count_reg;

endmodule

// File: rtl/if_inst_queue.sv
// Instruction fetch queue: buffers fetch packets in order for dispatch, throttles
// fetch via a registered enable and drops everything on a certain-branch flush.
module if_inst_queue
   import if_inst_queue_pkg::*;
#(
   parameter int DEPTH = INST_QUEUE_DEPTH,
   parameter int SKID  = INST_QUEUE_SKID,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clock,
   input  logic          reset,
   input  IF_ID_PACKET   if_packet_in,
   output logic          if_valid,
   input  logic          flush,
   input  logic          dispatch_ready,
   output IF_ID_PACKET   out_packet,
   output logic [CW-1:0] count,
   output logic          overflow_err
);

   localparam int PW = $clog2(DEPTH);
   // Fetch enable is registered, so stop it early enough to land the in-flight packet.
   localparam logic [CW-1:0] FETCH_STOP_LEVEL = CW'(DEPTH - SKID);

   IF_ID_PACKET storage [DEPTH];

   logic          do_push, do_pop, full, empty;
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count_next;
   logic          if_valid_reg;
   logic          overflow_reg;

   if_inst_queue_fifo_ctrl #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) u_ctrl (
      .clock      (clock),
      .reset      (reset),
      .flush      (flush),
      .enq_valid  (if_packet_in.valid),
      .deq_ready  (dispatch_ready),
      .do_push    (do_push),
      .do_pop     (do_pop),
      .full       (full),
      .empty      (empty),
      .head       (head),
      .tail       (tail),
      .count      (count),
      .count_next (count_next)
   );

   always_ff @(posedge clock) begin
      if (do_push)
         storage[tail] <= if_packet_in;
   end

   always_comb begin
      out_packet       = storage[head];
      out_packet.valid = !empty;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         if_valid_reg <= 1'b1;
         overflow_reg <= 1'b0;
      end else begin
         if_valid_reg <= (count_next < FETCH_STOP_LEVEL);
         if (if_packet_in.valid && full && !dispatch_ready && !flush)
            overflow_reg <= 1'b1;
      end
   end

   assign if_valid     = if_valid_reg;
   assign overflow_err = overflow_reg;

endmodule

// File: tb/tb_if_inst_queue.sv
// Randomised and directed bench for if_inst_queue against a queue-based reference.
module tb_if_inst_queue;
   import if_inst_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int SKID  = 1;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clock;
   logic          reset;
   IF_ID_PACKET   if_packet_in;
   logic          if_valid;
   logic          flush;
   logic          dispatch_ready;
   IF_ID_PACKET   out_packet;
   logic [CW-1:0] count;
   logic          overflow_err;

   int n_total = 0;
   int n_pass  = 0;

   if_inst_queue #(.DEPTH(DEPTH), .SKID(SKID)) dut (
      .clock          (clock),
      .reset          (reset),
      .if_packet_in   (if_packet_in),
      .if_valid       (if_valid),
      .flush          (flush),
      .dispatch_ready (dispatch_ready),
      .out_packet     (out_packet),
      .count          (count),
      .overflow_err   (overflow_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic IF_ID_PACKET make_pkt(input logic v, input logic [31:0] pc);
      IF_ID_PACKET p;
      p.valid = v;
      p.PC    = pc;
      p.NPC   = pc + 32'd4;
      p.inst  = (pc * 32'd3) ^ 32'hDEAD_BEEF;
      return p;
   endfunction

   // Reference: a plain queue of accepted packets plus the two flag bits.
   IF_ID_PACKET model_q [$];
   logic        model_ovf  = 1'b0;
   logic        model_ifv  = 1'b1;
   logic        model_live = 1'b0;

   always @(posedge clock) begin
      if (reset) begin
         model_q.delete();
         model_ovf  = 1'b0;
         model_ifv  = 1'b1;
         model_live = 1'b1;
      end else if (flush) begin
         model_q.delete();
         model_ifv = 1'b1;
      end else begin
         automatic bit pop  = (model_q.size() > 0) && dispatch_ready;
         automatic bit push = if_packet_in.valid && (model_q.size() < DEPTH || pop);
         if (if_packet_in.valid && model_q.size() == DEPTH && !dispatch_ready)
            model_ovf = 1'b1;
         if (pop)
            void'(model_q.pop_front());
         if (push)
            model_q.push_back(if_packet_in);
         model_ifv = (model_q.size() < DEPTH - SKID);
      end
   end

   always @(negedge clock) begin
      if (model_live) begin
         chk("count", 64'(count), 64'(model_q.size()));
         chk("out_valid", 64'(out_packet.valid), 64'(model_q.size() != 0));
         chk("if_valid", 64'(if_valid), 64'(model_ifv));
         chk("overflow_err", 64'(overflow_err), 64'(model_ovf));
         if (model_q.size() != 0) begin
            chk("out_pc", 64'(out_packet.PC), 64'(model_q[0].PC));
            chk("out_npc", 64'(out_packet.NPC), 64'(model_q[0].NPC));
            chk("out_inst", 64'(out_packet.inst), 64'(model_q[0].inst));
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rs);
      if_packet_in   = make_pkt(v, pc);
      dispatch_ready = rdy;
      flush          = fl;
      reset          = rs;
      @(posedge clock);
      #1;
   endtask

   logic [31:0] drain_exp [8];
   int          pushed, seen, cyc;

   initial begin
      drain_exp = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h24};
      if_packet_in   = make_pkt(1'b0, 32'h0);
      dispatch_ready = 1'b0;
      flush          = 1'b0;
      reset          = 1'b1;
      @(posedge clock);
      #1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_valid", 64'(out_packet.valid), 64'd0);
      chk("rst_if_valid", 64'(if_valid), 64'd1);
      chk("rst_ovf", 64'(overflow_err), 64'd0);

      // Three packets, no dispatch
      drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
      chk("first_valid", 64'(out_packet.valid), 64'd1);
      chk("first_pc", 64'(out_packet.PC), 64'h0);
      drive(1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h8, 1'b0, 1'b0, 1'b0);
      chk("three_count", 64'(count), 64'd3);
      chk("three_pc", 64'(out_packet.PC), 64'h0);

      // Fill to full and overflow
      drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h14, 1'b0, 1'b0, 1'b0);
      chk("six_if_valid", 64'(if_valid), 64'd1);
      drive(1'b1, 32'h18, 1'b0, 1'b0, 1'b0);
      chk("seven_count", 64'(count), 64'd7);
      chk("seven_if_valid", 64'(if_valid), 64'd0);
      drive(1'b1, 32'h1C, 1'b0, 1'b0, 1'b0);
      chk("eight_count", 64'(count), 64'd8);
      chk("eight_ovf", 64'(overflow_err), 64'd0);
      drive(1'b1, 32'h20, 1'b0, 1'b0, 1'b0);
      chk("ninth_count", 64'(count), 64'd8);
      chk("ninth_ovf", 64'(overflow_err), 64'd1);

      // Full queue with simultaneous push and pop
      drive(1'b1, 32'h24, 1'b1, 1'b0, 1'b0);
      chk("full_swap_count", 64'(count), 64'd8);
      chk("full_swap_head", 64'(out_packet.PC), 64'h4);
      for (int j = 0; j < 8; j++) begin
         chk("drain_pc", 64'(out_packet.PC), 64'(drain_exp[j]));
         drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("drained_count", 64'(count), 64'd0);
      chk("drained_if_valid", 64'(if_valid), 64'd1);

      // Stream of 20 across pointer wrap, random dispatch
      pushed = 0;
      seen   = 0;
      cyc    = 0;
      while ((pushed < 20 || seen < 20) && cyc < 600) begin
         automatic logic v   = if_valid && (pushed < 20) && ($urandom_range(0, 3) != 0);
         automatic logic rdy = ($urandom_range(0, 2) != 0);
         if (out_packet.valid && rdy) begin
            chk("stream_order", 64'(out_packet.PC), 64'(32'h100 + 32'(4 * seen)));
            seen++;
         end
         drive(v, 32'h100 + 32'(4 * pushed), rdy, 1'b0, 1'b0);
         if (v)
            pushed++;
         cyc++;
      end
      chk("stream_seen", 64'(seen), 64'd20);

      // Flush with a concurrent push and pop
      for (int j = 0; j < 5; j++)
         drive(1'b1, 32'h200 + 32'(4 * j), 1'b0, 1'b0, 1'b0);
      chk("pre_flush_count", 64'(count), 64'd5);
      drive(1'b1, 32'h40, 1'b1, 1'b1, 1'b0);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_valid", 64'(out_packet.valid), 64'd0);
      chk("flush_if_valid", 64'(if_valid), 64'd1);
      chk("flush_keeps_ovf", 64'(overflow_err), 64'd1);
      drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
      chk("post_flush_pc", 64'(out_packet.PC), 64'h1111_1111);

      // Reset mid-stream clears the sticky flag too
      for (int j = 0; j < 3; j++)
         drive(1'b1, 32'h300 + 32'(4 * j), 1'b0, 1'b0, 1'b0);
      chk("pre_reset_count", 64'(count), 64'd4);
      drive(1'b1, 32'h500, 1'b1, 1'b1, 1'b1);
      chk("mid_rst_count", 64'(count), 64'd0);
      chk("mid_rst_valid", 64'(out_packet.valid), 64'd0);
      chk("mid_rst_ovf", 64'(overflow_err), 64'd0);
      chk("mid_rst_if_valid", 64'(if_valid), 64'd1);

      // Free-running random traffic checked by the reference every cycle
      for (int n = 0; n < 3000; n++) begin
         automatic logic v   = ($urandom_range(0, 3) != 0);
         automatic logic rdy = ($urandom_range(0, 2) == 0);
         automatic logic fl  = ($urandom_range(0, 59) == 0);
         automatic logic rs  = ($urandom_range(0, 399) == 0);
         drive(v, $urandom & 32'hFFFF_FFFC, rdy, fl, rs);
      end

      @(negedge clock);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
